gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8: operand width per channel; WIDTH >= 1.
REQ-002 Parameter CHANNELS, default 4: number of independent channels and io_pin bits; CHANNELS >= 1.
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth; SYNC_STAGES >= 2.
REQ-004 Parameter TURN, default 1: turnaround cycles (high-Z) before a pin is driven; TURN >= 1.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 data_a  input  CHANNELS*WIDTH  operand A; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-009 data_b  input  CHANNELS*WIDTH  operand B; same packing.
REQ-010 mode  input  2*CHANNELS  direction mode per channel: 00 parity, 01 force input, 10 force output, 11 treated as force input.
REQ-011 irq_en  input  CHANNELS  per-channel interrupt enable.
REQ-012 irq_clear  input  CHANNELS  write-one-to-clear of irq_pending.
REQ-013 result  output  CHANNELS*(WIDTH+1)  registered sum per channel, packed [c*(WIDTH+1) +: WIDTH+1].
REQ-014 io_pin  inout  CHANNELS  bidirectional pins.
REQ-015 dir_out  output  CHANNELS  1 while the channel actively drives its pin.
REQ-016 pin_in  output  CHANNELS  synchronised pin value.
REQ-017 irq_pending  output  CHANNELS  sticky edge flags.
REQ-018 irq  output  1  OR over channels of irq_pending & irq_en, registered.

Function
REQ-019 result[c] SHALL equal data_a[c] + data_b[c] zero-extended to WIDTH+1 bits, with one cycle of latency.
REQ-020 The target direction SHALL be: in mode 00, output when the registered result bit 0 is 1; in mode 10, output; in modes 01 and 11, input.
REQ-021 Each channel SHALL run an FSM with four states: IN, TO_OUT, OUT, TO_IN.
REQ-022 IN, target output: go to TO_OUT and load the counter with TURN.
REQ-023 TO_OUT: pin held at Z; counter decrements; at counter 0 go to OUT. If the target returns to input, go directly to IN.
REQ-024 OUT: drive io_pin with result bit WIDTH (carry), dir_out=1. If the target is input, go to TO_IN with the counter loaded with SYNC_STAGES. The pin is released (Z) in the same cycle the state leaves OUT.
REQ-025 TO_IN: pin held at Z; edge detection suppressed; counter decrements; at 0 go to IN. If the target is output, go to TO_OUT.
REQ-026 io_pin[c] SHALL be Z in every state except OUT.
REQ-027 io_pin SHALL pass through a SYNC_STAGES flop chain to pin_in in every state.
REQ-028 In state IN only, any change of pin_in from the previous cycle SHALL set irq_pending[c] on the next edge.
REQ-029 irq_clear[c] SHALL clear irq_pending[c]; an edge detected in the same cycle wins, so the bit stays set.
REQ-030 irq SHALL update one cycle after irq_pending or irq_en changes.
REQ-031 Channels SHALL be fully independent; no channel's state affects another's.

Reset
REQ-032 When rst=1 at a clk edge, the following SHALL be cleared to 0: result, synchroniser flops, pin_in, edge history, irq_pending, irq and counters.
REQ-033 During reset, every FSM SHALL go to IN, dir_out SHALL be 0 and io_pin SHALL be Z, including when reset is asserted mid-turnaround.
REQ-034 After reset release, edges SHALL be detected only from the second cycle, against the reset value of 0.

Structure
REQ-035 Package gpio_bank_pkg SHALL hold the FSM state enum and the mode encoding constants (MODE_PARITY, MODE_IN, MODE_OUT).
REQ-036 Sub-module gpio_channel SHALL implement one channel (adder, FSM, synchroniser, edge/pending logic) and be instantiated CHANNELS times via generate; gpio_bank SHALL own only the irq reduction.

Verification (WIDTH=8, CHANNELS=4, SYNC_STAGES=2, TURN=1)
REQ-037 ch0 a=0x44, b=0x22, mode 00 -> result=0x066 after 1 cycle; dir_out[0]=0; io_pin[0]=Z throughout.
REQ-038 ch0 a=0x45, b=0x22, mode 00 -> result=0x067 at cycle 1; TO_OUT (Z) at cycle 2; dir_out[0]=1 and io_pin[0]=0 from cycle 3.
REQ-039 ch1 a=0xFF, b=0x01, mode 10 -> result=0x100; pin driven 1 after the turnaround; mode set to 01 -> Z in the next cycle; an opposite value driven by the bench during TO_IN leaves irq_pending[1]=0.
REQ-040 ch2 input, irq_en[2]=1, bench drives 0->1 -> pin_in[2]=1 two cycles later; irq_pending[2]=1 one cycle after that; irq=1 one cycle later. irq_clear[2] pulsed in the same cycle as a new 1->0 edge -> pending stays 1.
REQ-041 rst asserted for one cycle while ch0 is in TO_OUT -> all pins Z, dir_out=0, result=0, irq_pending=0, irq=0 on the next edge.
REQ-042 All four channels active at once with random operands and modes -> each channel matches a per-channel reference model, with no cross-channel interaction.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: channel FSM states, direction mode encodings and sizing helper.
package gpio_bank_pkg;
  typedef enum logic [1:0] {ST_IN, ST_TO_OUT, ST_OUT, ST_TO_IN} gpio_state_e;
  localparam logic [1:0] MODE_PARITY = 2'b00;
  localparam logic [1:0] MODE_IN     = 2'b01;
  localparam logic [1:0] MODE_OUT    = 2'b10;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/gpio_channel.sv
// gpio_channel: one GPIO channel with registered adder, direction FSM with
// turnaround, input synchroniser and sticky edge-pending flag.
module gpio_channel
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic [1:0]       mode_i,
  input  logic             irq_clear_i,
  output logic [WIDTH:0]   result_o,
  inout  wire              io_pin,
  output logic             dir_out_o,
  output logic             pin_in_o,
  output logic             irq_pending_o
);
  localparam int CW = $clog2(max_int(TURN, SYNC_STAGES) + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [WIDTH:0]         result_q;
  gpio_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, pend_q, pend_d, tgt_out, edge_det;
  assign tgt_out = mode_i == MODE_OUT || (mode_i == MODE_PARITY && result_q[0]);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IN: if (tgt_out) begin
        state_d = ST_TO_OUT;
        cnt_d   = CW'(TURN);
      end
      ST_TO_OUT: if (!tgt_out) begin
        state_d = ST_IN;
        cnt_d   = '0;
      end else begin
        state_d = cnt_q == ONE ? ST_OUT : ST_TO_OUT;
        cnt_d   = cnt_q - ONE;
      end
      ST_OUT: if (!tgt_out) begin
        state_d = ST_TO_IN;
        cnt_d   = CW'(SYNC_STAGES);
      end
      default: if (tgt_out) begin
        state_d = ST_TO_OUT;
        cnt_d   = CW'(TURN);
      end else begin
        state_d = cnt_q == ONE ? ST_IN : ST_TO_IN;
        cnt_d   = cnt_q - ONE;
      end
    endcase
  end
  assign edge_det = state_q == ST_IN && sync_q[SYNC_STAGES-1] != prev_q;
  assign pend_d   = edge_det | (pend_q & ~irq_clear_i);
  // Outside IN the history is preloaded with the next pin_in value, so the
  // first IN cycle never flags a change that happened during turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      state_q  <= ST_IN;
      cnt_q    <= '0;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      result_q <= {1'b0, data_a_i} + {1'b0, data_b_i};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], io_pin};
      prev_q   <= state_q == ST_IN ? sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-2];
      pend_q   <= pend_d;
    end
  end
  assign dir_out_o     = state_q == ST_OUT && !rst;
  assign io_pin        = dir_out_o ? result_q[WIDTH] : 1'bz;
  assign result_o      = result_q;
  assign pin_in_o      = sync_q[SYNC_STAGES-1];
  assign irq_pending_o = pend_q;
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: CHANNELS independent gpio_channel instances plus the
// registered interrupt reduction.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TURN        = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*WIDTH-1:0]      data_a,
  input  logic [CHANNELS*WIDTH-1:0]      data_b,
  input  logic [2*CHANNELS-1:0]          mode,
  input  logic [CHANNELS-1:0]            irq_en,
  input  logic [CHANNELS-1:0]            irq_clear,
  output logic [CHANNELS*(WIDTH+1)-1:0]  result,
  inout  wire  [CHANNELS-1:0]            io_pin,
  output logic [CHANNELS-1:0]            dir_out,
  output logic [CHANNELS-1:0]            pin_in,
  output logic [CHANNELS-1:0]            irq_pending,
  output logic                           irq
);
  logic irq_q;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gpio_channel #(
      .WIDTH(WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .TURN(TURN)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .data_a_i(data_a[c*WIDTH +: WIDTH]),
      .data_b_i(data_b[c*WIDTH +: WIDTH]),
      .mode_i(mode[c*2 +: 2]),
      .irq_clear_i(irq_clear[c]),
      .result_o(result[c*(WIDTH+1) +: WIDTH+1]),
      .io_pin(io_pin[c]),
      .dir_out_o(dir_out[c]),
      .pin_in_o(pin_in[c]),
      .irq_pending_o(irq_pending[c])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |(irq_pending & irq_en);
  end
  assign irq = irq_q;
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed checks of gpio_bank with hand-computed expectations.
module tb_gpio_bank;
  logic        clk, rst;
  logic [31:0] data_a, data_b;
  logic [7:0]  mode;
  logic [3:0]  irq_en, irq_clear, drv_en, drv_val;
  logic [35:0] result;
  wire  [3:0]  io_pin;
  logic [3:0]  dir_out, pin_in, irq_pending;
  logic        irq;
  int          n_chk = 0, n_fail = 0;
  logic [7:0]  ea[4], eb[4];
  logic [1:0]  em[4];
  logic [8:0]  sum;
  logic        tgt;
  gpio_bank #(.WIDTH(8), .CHANNELS(4), .SYNC_STAGES(2), .TURN(1)) dut (
    .clk(clk), .rst(rst), .data_a(data_a), .data_b(data_b), .mode(mode),
    .irq_en(irq_en), .irq_clear(irq_clear), .result(result), .io_pin(io_pin),
    .dir_out(dir_out), .pin_in(pin_in), .irq_pending(irq_pending), .irq(irq)
  );
  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign io_pin[g] = drv_en[g] ? drv_val[g] : 1'bz;
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int c, input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    data_a[c*8 +: 8] = a;
    data_b[c*8 +: 8] = b;
    mode[c*2 +: 2]   = m;
  endtask
  function automatic logic [8:0] res(input int c);
    return result[c*9 +: 9];
  endfunction
  initial begin
    rst = 1'b1; data_a = '0; data_b = '0; mode = 8'b01010101;
    irq_en = '0; irq_clear = '0; drv_en = 4'hF; drv_val = '0;
    cyc(); cyc();
    check("rst_result", result, 0);
    check("rst_dir", dir_out, 0);
    check("rst_pend", irq_pending, 0);
    check("rst_irq", irq, 0);
    check("rst_pin_in", pin_in, 0);
    rst = 1'b0;
    cyc();
    check("post_rst_pend", irq_pending, 0);
    // ch0 even sum in parity mode stays input
    set_ch(0, 8'h44, 8'h22, 2'b00);
    cyc();
    check("a_res", res(0), 9'h066);
    check("a_dir1", dir_out[0], 0);
    cyc(); cyc();
    check("a_dir3", dir_out[0], 0);
    // ch0 odd sum in parity mode turns around to output
    set_ch(0, 8'h45, 8'h22, 2'b00);
    drv_en[0] = 1'b0;
    cyc();
    check("b_res", res(0), 9'h067);
    check("b_dir1", dir_out[0], 0);
    cyc();
    check("b_dir2_turn", dir_out[0], 0);
    cyc();
    check("b_dir3", dir_out[0], 1);
    check("b_pin3", io_pin[0], 0);
    cyc();
    check("b_dir4", dir_out[0], 1);
    // ch1 forced output with carry, then back to input with opposing drive
    set_ch(1, 8'hFF, 8'h01, 2'b10);
    drv_en[1] = 1'b0;
    cyc();
    check("c_res", res(1), 9'h100);
    check("c_dir1_turn", dir_out[1], 0);
    cyc();
    check("c_dir2", dir_out[1], 1);
    check("c_pin2", io_pin[1], 1);
    cyc(); cyc();
    check("c_pin_in", pin_in[1], 1);
    mode[3:2] = 2'b01;
    cyc();
    check("c_release", dir_out[1], 0);
    drv_en[1] = 1'b1; drv_val[1] = 1'b0;
    cyc();
    check("c_toin_pend", irq_pending[1], 0);
    cyc(); cyc();
    check("c_pin_in0", pin_in[1], 0);
    check("c_pend_a", irq_pending[1], 0);
    cyc();
    check("c_pend_b", irq_pending[1], 0);
    // ch2 input edge, irq, clear colliding with a new edge
    irq_en = 4'b0100;
    drv_val[2] = 1'b1;
    cyc();
    check("d_pin_in_t0", pin_in[2], 0);
    cyc();
    check("d_pin_in_t1", pin_in[2], 1);
    check("d_pend_t1", irq_pending[2], 0);
    cyc();
    check("d_pend_t2", irq_pending[2], 1);
    check("d_irq_t2", irq, 0);
    cyc();
    check("d_irq_t3", irq, 1);
    irq_en = 4'b0000;
    cyc();
    check("d_irq_en_off", irq, 0);
    irq_en = 4'b0100;
    cyc();
    check("d_irq_en_on", irq, 1);
    drv_val[2] = 1'b0;
    cyc(); cyc();
    check("d_pin_in_fall", pin_in[2], 0);
    irq_clear[2] = 1'b1;
    cyc();
    check("d_clear_vs_edge", irq_pending[2], 1);
    cyc();
    check("d_clear", irq_pending[2], 0);
    irq_clear = '0;
    cyc();
    check("d_irq_drop", irq, 0);
    check("d_other_pend", irq_pending[3], 0);
    // all channels with random operands and modes
    irq_en = '0; drv_en = '0;
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < 4; c++) begin
        ea[c] = 8'($urandom_range(0, 255));
        eb[c] = 8'($urandom_range(0, 255));
        em[c] = 2'($urandom_range(0, 3));
        set_ch(c, ea[c], eb[c], em[c]);
      end
      cyc();
      for (int c = 0; c < 4; c++) check($sformatf("e_res%0d_%0d", it, c), res(c), {1'b0, ea[c]} + {1'b0, eb[c]});
      repeat (5) cyc();
      for (int c = 0; c < 4; c++) begin
        sum = {1'b0, ea[c]} + {1'b0, eb[c]};
        tgt = em[c] == 2'b10 || (em[c] == 2'b00 && sum[0]);
        check($sformatf("e_dir%0d_%0d", it, c), dir_out[c], tgt);
        if (tgt) check($sformatf("e_pin%0d_%0d", it, c), io_pin[c], sum[8]);
      end
    end
    // reset in the middle of ch0 turnaround
    mode = 8'b01010101; irq_en = 4'hF;
    repeat (4) cyc();
    set_ch(0, 8'hFF, 8'hFF, 2'b10);
    cyc();
    check("f_turn", dir_out[0], 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("f_dir", dir_out, 0);
    check("f_result", result, 0);
    check("f_pend", irq_pending, 0);
    check("f_irq", irq, 0);
    check("f_pin_in", pin_in, 0);
    cyc();
    check("f_turn2", dir_out[0], 0);
    cyc();
    check("f_dir_out", dir_out[0], 1);
    check("f_pin", io_pin[0], 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
